// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, latencies,
// sequencer state encoding and a helper that classifies multicycle ops.
package mdu_pkg;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } seq_state_e;

  // mult, multu, div and divu occupy the unit for several cycles
  function automatic logic is_long_op(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// Sequencer for the multiply/divide unit: accepts a multicycle op while idle,
// latches its operands, counts the latency down and pulses o_done on the
// final busy cycle.
//
//   state  | meaning
//   S_IDLE | no op in flight, a long op on i_start is accepted
//   S_RUN  | op in flight, counter decrements, done when it reads 1
module mdu_seq
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_op,
  output logic [31:0] o_a,
  output logic [31:0] o_b
);

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             w_accept;
  logic             w_done;

  assign w_accept = i_start && (r_state == S_IDLE) && is_long_op(i_op);

  // state, counter and operand latch; operands only move on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_op <= i_op;
        r_a  <= i_a;
        r_b  <= i_b;
      end
    end
  end

  // next state, latency load and done pulse
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = ((i_op == MD_MULT) || (i_op == MD_MULTU)) ?
                        CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_busy = (r_state == S_RUN);
  assign o_done = w_done;
  assign o_op   = r_op;
  assign o_a    = r_a;
  assign o_b    = r_b;

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO. Fixed-latency multicycle ops with exact
// MIPS results; mthi/mtlo write immediately when idle.
// Build option MDU_DIVZERO_KEEP_EN: when defined, a divide by zero leaves
// HI/LO untouched; otherwise it writes lo=0xFFFFFFFF, hi=dividend.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        bsy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic        w_busy;
  logic        w_done;
  logic [2:0]  w_op_q;
  logic [31:0] w_a_q;
  logic [31:0] w_b_q;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;

  mdu_seq u_seq (
    .clk     (clk),
    .rst     (rst),
    .i_start (start),
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_op    (w_op_q),
    .o_a     (w_a_q),
    .o_b     (w_b_q)
  );

  // Products: sign-extended operands give the signed product modulo 2^64.
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  assign w_prod_s = {{32{w_a_q[31]}}, w_a_q} * {{32{w_b_q[31]}}, w_b_q};
  assign w_prod_u = {32'b0, w_a_q} * {32'b0, w_b_q};

  // Signed divide on magnitudes, then restore signs. The zero divisor is
  // replaced by 1 only to keep the divider defined; its result is muxed away.
  logic        w_neg_a;
  logic        w_neg_b;
  logic        w_div_zero;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_den_s;
  logic [31:0] w_den_u;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;

  assign w_neg_a    = w_a_q[31];
  assign w_neg_b    = w_b_q[31];
  assign w_div_zero = (w_b_q == 32'd0);
  assign w_abs_a    = w_neg_a ? -w_a_q : w_a_q;
  assign w_abs_b    = w_neg_b ? -w_b_q : w_b_q;
  assign w_den_s    = w_div_zero ? 32'd1 : w_abs_b;
  assign w_den_u    = w_div_zero ? 32'd1 : w_b_q;
  assign w_q_mag    = w_abs_a / w_den_s;
  assign w_r_mag    = w_abs_a % w_den_s;
  assign w_q_s      = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
  assign w_r_s      = w_neg_a ? -w_r_mag : w_r_mag;
  assign w_q_u      = w_a_q / w_den_u;
  assign w_r_u      = w_a_q % w_den_u;

  // HI/LO next value: result on the final busy cycle, mthi/mtlo when idle
  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (w_done) begin
      case (w_op_q)
        MD_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
        MD_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
        MD_DIV, MD_DIVU: begin
          if (w_div_zero) begin
`ifdef MDU_DIVZERO_KEEP_EN
            w_hi_nxt = r_hi;
            w_lo_nxt = r_lo;
`else
            w_hi_nxt = w_a_q;
            w_lo_nxt = 32'hFFFF_FFFF;
`endif
          end else if (w_op_q == MD_DIV) begin
            w_hi_nxt = w_r_s;
            w_lo_nxt = w_q_s;
          end else begin
            w_hi_nxt = w_r_u;
            w_lo_nxt = w_q_u;
          end
        end
        default: ;
      endcase
    end else if (start && !w_busy) begin
      if (op == MD_MTHI) w_hi_nxt = a;
      if (op == MD_MTLO) w_lo_nxt = a;
    end
  end

  // HI/LO registers; reset mid-operation also clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

  assign busy = w_busy;
  assign bsy  = w_busy | (start & is_long_op(op));
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus randomized ops,
// checked against an arithmetic reference model of HI/LO and latency.
module tb_mdu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        bsy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .bsy   (bsy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [2:0] o);
    if (o == 3'd1 || o == 3'd2) return 5;
    if (o == 3'd3 || o == 3'd4) return 10;
    return 0;
  endfunction

  function automatic void model(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib);
    longint      sa, sb, q, r;
    logic [63:0] p;
    case (o)
      3'd1: begin
        p = 64'(longint'($signed(ia)) * longint'($signed(ib)));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      3'd2: begin
        p = 64'(ia) * 64'(ib);
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      3'd3, 3'd4: begin
        if (ib == 32'd0) begin
`ifndef MDU_DIVZERO_KEEP_EN
          m_hi = ia; m_lo = 32'hFFFF_FFFF;
`endif
        end else if (o == 3'd3) begin
          sa = longint'($signed(ia));
          sb = longint'($signed(ib));
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = ia / ib; m_hi = ia % ib;
        end
      end
      3'd5: m_hi = ia;
      3'd6: m_lo = ia;
      default: ;
    endcase
  endfunction

  // Issue one op from idle, scramble inputs while it runs, check bsy, latency and HI/LO.
  task automatic issue(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib, input string name);
    int   lat;
    int   cyc;
    logic exp_bsy;
    lat     = exp_lat(o);
    exp_bsy = (lat != 0);
    @(negedge clk);
    start = 1'b1; op = o; a = ia; b = ib;
    #1;
    total++;
    if (bsy !== exp_bsy) begin
      bad++; $display("FAIL %s bsy: got %b want %b", name, bsy, exp_bsy);
    end
    model(o, ia, ib);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    cyc = 0;
    if (lat != 0) begin
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (busy !== 1'b1) break;
        cyc++;
        a = $urandom; b = $urandom;
      end
    end else begin
      @(negedge clk);
      if (busy !== 1'b0) cyc = 99;
    end
    total++;
    if (cyc != lat) begin
      bad++; $display("FAIL %s busy_cycles: got %0d want %0d", name, cyc, lat);
    end
    total++;
    if (hi !== m_hi) begin
      bad++; $display("FAIL %s hi: got %h want %h", name, hi, m_hi);
    end
    total++;
    if (lo !== m_lo) begin
      bad++; $display("FAIL %s lo: got %h want %h", name, lo, m_lo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, bsy, hi, lo} !== 66'd0) begin
      bad++; $display("FAIL reset: got busy=%b bsy=%b hi=%h lo=%h want all zero", busy, bsy, hi, lo);
    end
    @(negedge clk);
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_directed();
    issue(3'd1, 32'hFFFF_FFFD, 32'd5, "mult_neg");
    total++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      bad++; $display("FAIL mult_neg_const: got %h%h want ffffffff_fffffff1", hi, lo);
    end
    issue(3'd4, 32'd7, 32'd2, "divu_7_2");
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
    total++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      bad++; $display("FAIL div_neg_const: got %h%h want ffffffff_fffffffd", hi, lo);
    end
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, "mult_min");
    total++;
    if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
      bad++; $display("FAIL mult_min_const: got %h%h want 40000000_00000000", hi, lo);
    end
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
  endtask

  task automatic test_divzero();
    issue(3'd5, 32'h11, 32'd0, "mthi_pre");
    issue(3'd6, 32'h22, 32'd0, "mtlo_pre");
    issue(3'd3, 32'd5, 32'd0, "div_zero");
    issue(3'd4, 32'hDEAD_BEEF, 32'd0, "divu_zero");
  endtask

  task automatic test_nop();
    issue(3'd0, 32'hAAAA_5555, 32'd1, "nop");
    issue(3'd7, 32'h5555_AAAA, 32'd1, "op7");
  endtask

  task automatic test_busy_ignore();
    logic [31:0] ea, eb;
    int cyc;
    ea = $urandom; eb = $urandom;
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = ea; b = eb;
    model(3'd2, ea, eb);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cyc++;
      if (cyc == 2) begin
        start = 1'b1; op = 3'd5; a = 32'h1234;
        #1;
        total++;
        if (bsy !== 1'b1) begin
          bad++; $display("FAIL busy_mthi bsy: got %b want 1", bsy);
        end
      end else begin
        start = 1'b0; a = $urandom; b = $urandom;
      end
    end
    start = 1'b0;
    total++;
    if (cyc != 5) begin
      bad++; $display("FAIL busy_ignore cycles: got %0d want 5", cyc);
    end
    total++;
    if ({hi, lo} !== {m_hi, m_lo}) begin
      bad++; $display("FAIL busy_ignore result: got %h%h want %h%h", hi, lo, m_hi, m_lo);
    end
    issue(3'd5, 32'h1234, 32'd0, "mthi_idle");
  endtask

  task automatic test_reset_abort();
    issue(3'd5, 32'hCAFE_0001, 32'd0, "mthi_abort_pre");
    issue(3'd6, 32'hCAFE_0002, 32'd0, "mtlo_abort_pre");
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, hi, lo} !== 65'd0) begin
      bad++; $display("FAIL reset_abort: got busy=%b hi=%h lo=%h want zero", busy, hi, lo);
    end
    @(negedge clk);
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (15) @(negedge clk);
    total++;
    if ({busy, hi, lo} !== 65'd0) begin
      bad++; $display("FAIL reset_abort_late: got busy=%b hi=%h lo=%h want zero", busy, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] ra, rb;
    for (int i = 0; i < 60; i++) begin
      o  = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      issue(o, ra, rb, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_divzero();
    test_nop();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
